// File: rtl/axi_cut.sv
// AXI4 / AXI-Lite pipeline cut: one two-slot spill register per channel so that
// valid, ready and payload are all registered. Bypass=1 degenerates to wires.

module axi_cut_spill #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);

  logic  a_full_q, b_full_q;
  data_t a_data_q, b_data_q;
  logic  a_fill, a_drain, b_fill, b_drain;

  // Slot B only catches what A could not hand downstream; A always feeds B or the output.
  assign a_fill  = valid_i & ready_o;
  assign a_drain = a_full_q & ~b_full_q;
  assign b_fill  = a_drain & ~ready_i;
  assign b_drain = b_full_q & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_fill) begin
        a_full_q <= 1'b1;
        a_data_q <= data_i;
      end else if (a_drain) begin
        a_full_q <= 1'b0;
      end
      if (b_fill) begin
        b_full_q <= 1'b1;
        b_data_q <= a_data_q;
      end else if (b_drain) begin
        b_full_q <= 1'b0;
      end
    end
  end

  assign ready_o = ~a_full_q | ~b_full_q;
  assign valid_o = a_full_q | b_full_q;
  assign data_o  = b_full_q ? b_data_q : a_data_q;

endmodule

module axi_cut #(
  parameter bit  Bypass    = 1'b0,
  parameter type aw_chan_t = logic,
  parameter type w_chan_t  = logic,
  parameter type b_chan_t  = logic,
  parameter type ar_chan_t = logic,
  parameter type r_chan_t  = logic,
  parameter type axi_req_t = struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  },
  parameter type axi_rsp_t = struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    ar_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  }
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_resp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_resp_i
);

  if (Bypass) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign mst_req_o      = slv_req_i;
    assign slv_resp_o     = mst_resp_i;
  end else begin : g_cut
    axi_cut_spill #(.data_t(aw_chan_t)) i_aw (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (slv_req_i.aw_valid),
      .ready_o (slv_resp_o.aw_ready),
      .data_i  (slv_req_i.aw),
      .valid_o (mst_req_o.aw_valid),
      .ready_i (mst_resp_i.aw_ready),
      .data_o  (mst_req_o.aw)
    );

    axi_cut_spill #(.data_t(w_chan_t)) i_w (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (slv_req_i.w_valid),
      .ready_o (slv_resp_o.w_ready),
      .data_i  (slv_req_i.w),
      .valid_o (mst_req_o.w_valid),
      .ready_i (mst_resp_i.w_ready),
      .data_o  (mst_req_o.w)
    );

    axi_cut_spill #(.data_t(ar_chan_t)) i_ar (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (slv_req_i.ar_valid),
      .ready_o (slv_resp_o.ar_ready),
      .data_i  (slv_req_i.ar),
      .valid_o (mst_req_o.ar_valid),
      .ready_i (mst_resp_i.ar_ready),
      .data_o  (mst_req_o.ar)
    );

    // Response channels flow downstream-to-upstream.
    axi_cut_spill #(.data_t(b_chan_t)) i_b (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (mst_resp_i.b_valid),
      .ready_o (mst_req_o.b_ready),
      .data_i  (mst_resp_i.b),
      .valid_o (slv_resp_o.b_valid),
      .ready_i (slv_req_i.b_ready),
      .data_o  (slv_resp_o.b)
    );

    axi_cut_spill #(.data_t(r_chan_t)) i_r (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (mst_resp_i.r_valid),
      .ready_o (mst_req_o.r_ready),
      .data_i  (mst_resp_i.r),
      .valid_o (slv_resp_o.r_valid),
      .ready_i (slv_req_i.r_ready),
      .data_o  (slv_resp_o.r)
    );
  end

endmodule

// File: tb/tb_axi_cut.sv
// Testbench for axi_cut: per-channel FIFO reference (capacity 2) plus a bypass
// instance compared against its own inputs.

module tb_axi_cut;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;

  typedef struct packed {
    aw_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    ar_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic w_ready; logic ar_ready;
    b_t b; logic b_valid; r_t r; logic r_valid;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  req_t slv_req, mst_req, mst_req_b;
  rsp_t slv_resp, mst_resp, slv_resp_b, mst_resp_b;

  // Channel index: 0=AW 1=W 2=AR 3=B 4=R
  logic [4:0]  iv, ordy, ov, ir;
  logic [63:0] idat [5];
  logic [63:0] od   [5];

  axi_cut #(
    .Bypass(1'b0), .aw_chan_t(aw_t), .w_chan_t(w_t), .b_chan_t(b_t),
    .ar_chan_t(ar_t), .r_chan_t(r_t), .axi_req_t(req_t), .axi_rsp_t(rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp)
  );

  axi_cut #(
    .Bypass(1'b1), .aw_chan_t(aw_t), .w_chan_t(w_t), .b_chan_t(b_t),
    .ar_chan_t(ar_t), .r_chan_t(r_t), .axi_req_t(req_t), .axi_rsp_t(rsp_t)
  ) dut_byp (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_resp_b),
    .mst_req_o(mst_req_b), .mst_resp_i(mst_resp_b)
  );

  always_comb begin
    slv_req          = '0;
    slv_req.aw       = idat[0][$bits(aw_t)-1:0];
    slv_req.aw_valid = iv[0];
    slv_req.w        = idat[1][$bits(w_t)-1:0];
    slv_req.w_valid  = iv[1];
    slv_req.ar       = idat[2][$bits(ar_t)-1:0];
    slv_req.ar_valid = iv[2];
    slv_req.b_ready  = ordy[3];
    slv_req.r_ready  = ordy[4];
    mst_resp          = '0;
    mst_resp.aw_ready = ordy[0];
    mst_resp.w_ready  = ordy[1];
    mst_resp.ar_ready = ordy[2];
    mst_resp.b        = idat[3][$bits(b_t)-1:0];
    mst_resp.b_valid  = iv[3];
    mst_resp.r        = idat[4][$bits(r_t)-1:0];
    mst_resp.r_valid  = iv[4];
  end

  always_comb begin
    ov = {slv_resp.r_valid, slv_resp.b_valid, mst_req.ar_valid, mst_req.w_valid, mst_req.aw_valid};
    ir = {mst_req.r_ready, mst_req.b_ready, slv_resp.ar_ready, slv_resp.w_ready, slv_resp.aw_ready};
    for (int unsigned c = 0; c < 5; c++) od[c] = '0;
    od[0][$bits(aw_t)-1:0] = mst_req.aw;
    od[1][$bits(w_t)-1:0]  = mst_req.w;
    od[2][$bits(ar_t)-1:0] = mst_req.ar;
    od[3][$bits(b_t)-1:0]  = slv_resp.b;
    od[4][$bits(r_t)-1:0]  = slv_resp.r;
  end

  // Reference: each channel is an in-order queue holding at most two beats.
  logic [63:0] mq [5][16];
  int unsigned wp [5], rp [5], cnt [5];
  logic [4:0]  hs_in, hs_out;
  int unsigned trace_ch, trace_n;
  logic [63:0] out_buf [64];
  int n_checks, n_errors;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cmask(input int unsigned c);
    int unsigned w;
    case (c)
      0:       w = $bits(aw_t);
      1:       w = $bits(w_t);
      2:       w = $bits(ar_t);
      3:       w = $bits(b_t);
      default: w = $bits(r_t);
    endcase
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Called between negedge and posedge with inputs already driven.
  task automatic cycle();
    logic [63:0] r;
    #1;
    check("byp_req", {30'd0, mst_req_b}, {30'd0, slv_req});
    check("byp_rsp", {110'd0, slv_resp_b}, {110'd0, mst_resp_b});
    hs_in  = iv & ir;
    hs_out = ov & ordy;
    if (hs_out[trace_ch] && trace_n < 64) begin
      out_buf[trace_n] = od[trace_ch];
      trace_n++;
    end
    @(posedge clk);
    for (int unsigned c = 0; c < 5; c++) begin
      if (hs_out[c]) begin rp[c] = (rp[c] + 1) % 16; cnt[c]--; end
      if (hs_in[c]) begin mq[c][wp[c]] = idat[c]; wp[c] = (wp[c] + 1) % 16; cnt[c]++; end
    end
    @(negedge clk);
    for (int unsigned c = 0; c < 5; c++) begin
      check($sformatf("valid_ch%0d", c), 160'(ov[c]), 160'(cnt[c] != 0));
      check($sformatf("ready_ch%0d", c), 160'(ir[c]), 160'(cnt[c] < 2));
      if (cnt[c] != 0) check($sformatf("data_ch%0d", c), 160'(od[c]), 160'(mq[c][rp[c]]));
    end
    r = rnd64();
    mst_resp_b = r[$bits(rsp_t)-1:0];
  endtask

  // Asynchronous assertion away from any edge; checks take effect before the next edge.
  task automatic do_reset();
    iv   = '0;
    ordy = '1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 160'(ov), 160'(5'h00));
    check("rst_ready", 160'(ir), 160'(5'h1f));
    for (int unsigned c = 0; c < 5; c++) begin
      check($sformatf("rst_data_ch%0d", c), 160'(od[c]), 160'(0));
      wp[c] = 0; rp[c] = 0; cnt[c] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    aw_t         aw;
    r_t          rb;
    logic [63:0] vals [3];
    logic [4:0]  held;
    int unsigned k, acc;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b1; iv = '0; ordy = '1; mst_resp_b = '0;
    trace_ch = 1; trace_n = 0; hs_in = '0; hs_out = '0;
    for (int unsigned c = 0; c < 5; c++) begin idat[c] = '0; wp[c] = 0; rp[c] = 0; cnt[c] = 0; end
    do_reset();

    // Single AW beat: visible downstream exactly one cycle after the handshake.
    aw = '{id: 4'd3, addr: 32'h1000, len: 8'd0};
    idat[0] = '0;
    idat[0][$bits(aw_t)-1:0] = aw;
    iv[0] = 1'b1;
    check("lat_aw_before", 160'(ov[0]), 160'(0));
    cycle();
    check("lat_aw_valid", 160'(ov[0]), 160'(1));
    check("lat_aw_payload", 160'(od[0]), {96'd0, 20'd0, aw});
    iv[0] = 1'b0;
    cycle();

    // W backpressure: two beats fit, the third waits until the stall is released.
    vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC;
    ordy[1] = 1'b0; k = 0; acc = 0;
    trace_ch = 1; trace_n = 0;
    for (int unsigned t = 0; t < 6; t++) begin
      iv[1] = (k < 3); idat[1] = vals[k % 3];
      cycle();
      if (hs_in[1]) begin k++; acc++; end
    end
    check("bp_accepted", 160'(acc), 160'(2));
    check("bp_w_ready_low", 160'(ir[1]), 160'(0));
    ordy[1] = 1'b1;
    for (int unsigned t = 0; t < 8; t++) begin
      iv[1] = (k < 3); idat[1] = vals[k % 3];
      cycle();
      if (hs_in[1]) k++;
    end
    check("bp_total", 160'(k), 160'(3));
    check("bp_out_n", 160'(trace_n), 160'(3));
    for (int unsigned i = 0; i < 3; i++) check($sformatf("bp_order%0d", i), 160'(out_buf[i]), 160'(vals[i]));

    // R streaming with both sides always ready.
    trace_ch = 4; trace_n = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      rb = '{id: 4'(i), data: 32'(i), resp: 2'd0, last: (i == 15)};
      idat[4] = '0;
      idat[4][$bits(r_t)-1:0] = rb;
      iv[4] = 1'b1;
      cycle();
      check("stream_accept", 160'(hs_in[4]), 160'(1));
    end
    iv[4] = 1'b0;
    cycle();
    check("stream_out_n", 160'(trace_n), 160'(16));
    for (int unsigned i = 0; i < 16; i++) begin
      rb = '{id: 4'(i), data: 32'(i), resp: 2'd0, last: (i == 15)};
      check($sformatf("stream_beat%0d", i), 160'(out_buf[i]), {111'd0, rb});
    end

    // Random traffic on all channels; upstream holds an offered beat until accepted.
    held = '0;
    for (int unsigned t = 0; t < 5000; t++) begin
      for (int unsigned c = 0; c < 5; c++) begin
        if (!held[c]) begin
          iv[c]   = ($urandom_range(0, 3) != 0);
          idat[c] = rnd64() & cmask(c);
        end
        ordy[c] = ($urandom_range(0, 1) != 0);
      end
      cycle();
      held = iv & ~hs_in;
    end

    // Fill every channel under a full stall, then reset mid-burst.
    ordy = '0;
    for (int unsigned t = 0; t < 3; t++) begin
      iv = '1;
      for (int unsigned c = 0; c < 5; c++) idat[c] = rnd64() & cmask(c);
      cycle();
    end
    check("mid_full_valid", 160'(ov), 160'(5'h1f));
    do_reset();
    for (int unsigned t = 0; t < 3; t++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
